// File: rtl/uart_rx_word.sv
// rtl/uart_rx_word.sv - 8N1 UART receiver assembling two bytes into one 16-bit word
// Low byte arrives first and each byte is LSB first; a stop bit sampled low discards the partial word.
module uart_rx_word #(
   parameter int CLKS_PER_BIT = 5208,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   output logic [15:0] rxData,
   output logic        rxValid,
   output logic        rxFrameErr,
   output logic        rxBusy
);

   localparam int CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TO_W      = $clog2(TO_CYCLES + 1);

   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [TO_W-1:0]  TO_M1   = TO_W'(TO_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t            state_q, state_d;
   logic              rx_meta_q, rx_s_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic [7:0]        low_q, low_d;
   logic              idx_q, idx_d;
   logic [TO_W-1:0]   to_q, to_d;
   logic [15:0]       data_q, data_d;
   logic              valid_q, valid_d;
   logic              ferr_q, ferr_d;
   logic              busy_q, busy_d;

   logic start_smp, bit_smp, stop_smp, timeout_hit;

   assign start_smp   = (state_q == S_START) && (cnt_q == HALF_M1);
   assign bit_smp     = (state_q == S_DATA)  && (cnt_q == FULL_M1);
   assign stop_smp    = (state_q == S_STOP)  && (cnt_q == FULL_M1);
   assign timeout_hit = (state_q == S_IDLE)  && idx_q && (to_q == TO_M1);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         low_q     <= '0;
         idx_q     <= 1'b0;
         to_q      <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         low_q     <= low_d;
         idx_q     <= idx_d;
         to_q      <= to_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (!rx_s_q) state_d = S_START;
         S_START: if (start_smp) state_d = rx_s_q ? S_IDLE : S_DATA;
         S_DATA:  if (bit_smp && (bit_q == 3'd7)) state_d = S_STOP;
         S_STOP:  if (stop_smp) state_d = rx_s_q ? S_IDLE : S_BREAK;
         S_BREAK: if (rx_s_q) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d   = '0;
      bit_d   = '0;
      shift_d = shift_q;
      low_d   = low_q;
      idx_d   = idx_q;
      to_d    = '0;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      busy_d  = busy_q;

      // Baud counter restarts on every state change and wraps each bit period.
      if ((state_d == state_q) &&
          ((state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP)))
         cnt_d = (cnt_q == FULL_M1) ? '0 : cnt_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            if (idx_q && !timeout_hit)
               to_d = to_q + 1'b1;
            if (timeout_hit) begin
               idx_d  = 1'b0;
               busy_d = 1'b0;
            end
            if (!rx_s_q) begin
               to_d   = '0;
               busy_d = 1'b1;
            end
         end
         S_START: begin
            if (start_smp && rx_s_q)
               busy_d = idx_q;
         end
         S_DATA: begin
            bit_d = bit_q;
            if (bit_smp) begin
               shift_d = {rx_s_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
            end
         end
         S_STOP: begin
            if (stop_smp) begin
               if (rx_s_q && !idx_q) begin
                  low_d = shift_q;
                  idx_d = 1'b1;
               end else if (rx_s_q) begin
                  data_d  = {shift_q, low_q};
                  valid_d = 1'b1;
                  idx_d   = 1'b0;
                  busy_d  = 1'b0;
               end else begin
                  ferr_d = 1'b1;
                  idx_d  = 1'b0;
                  busy_d = 1'b0;
               end
            end
         end
         default: ;
      endcase
   end

   assign rxData     = data_q;
   assign rxValid    = valid_q;
   assign rxFrameErr = ferr_q;
   assign rxBusy     = busy_q;

endmodule

// File: tb/tb_uart_rx_word.sv
// tb/tb_uart_rx_word.sv - self-checking bench for uart_rx_word
// Sent words go into a scoreboard queue; a negedge monitor pops one per rxValid pulse.
module tb_uart_rx_word;

   localparam int C  = 8;
   localparam int TB = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rx  = 1'b1;
   logic [15:0] rxData;
   logic        rxValid;
   logic        rxFrameErr;
   logic        rxBusy;

   int total     = 0;
   int bad       = 0;
   int valid_cnt = 0;
   int ferr_cnt  = 0;
   logic [15:0] exp_q[$];
   logic [15:0] exp_w;
   logic        prev_valid = 1'b0;
   logic        prev_ferr  = 1'b0;

   always #5 clk = ~clk;

   uart_rx_word #(.CLKS_PER_BIT(C), .TIMEOUT_BITS(TB)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .rxData     (rxData),
      .rxValid    (rxValid),
      .rxFrameErr (rxFrameErr),
      .rxBusy     (rxBusy)
   );

   always @(negedge clk) begin
      if (rxValid === 1'b1) begin
         valid_cnt++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_valid: got rxData=%h, required no pulse", rxData);
         end else begin
            exp_w = exp_q.pop_front();
            if (rxData !== exp_w) begin
               bad++;
               $display("FAIL valid_data: got %h required %h", rxData, exp_w);
            end
         end
         total++;
         if (rxBusy !== 1'b0) begin
            bad++;
            $display("FAIL busy_at_valid: got %b required 0", rxBusy);
         end
         total++;
         if (rxFrameErr !== 1'b0) begin
            bad++;
            $display("FAIL valid_and_ferr: got ferr=%b required 0", rxFrameErr);
         end
         if (prev_valid === 1'b1) begin
            total++;
            bad++;
            $display("FAIL valid_width: got 2+ cycles required 1");
         end
      end
      if (rxFrameErr === 1'b1) begin
         ferr_cnt++;
         if (prev_ferr === 1'b1) begin
            total++;
            bad++;
            $display("FAIL ferr_width: got 2+ cycles required 1");
         end
      end
      prev_valid = rxValid;
      prev_ferr  = rxFrameErr;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      tick(C);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop);
      rx = 1'b1;
   endtask

   task automatic send_word(input logic [15:0] w);
      exp_q.push_back(w);
      send_byte(w[7:0], 1'b1);
      send_byte(w[15:8], 1'b1);
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         tick(1);
         n++;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL %s_drain: got pending=%0d required 0", name, exp_q.size());
         exp_q.delete();
      end
      tick(4);
   endtask

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] req);
      total++;
      if (got !== req) begin
         bad++;
         $display("FAIL %s: got %h required %h", name, got, req);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rx = i[0];
         tick(1);
         total++;
         if ({rxValid, rxFrameErr, rxBusy} !== 3'b000 || rxData !== 16'h0000) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b f=%b b=%b d=%h required all 0",
                     rxValid, rxFrameErr, rxBusy, rxData);
         end
      end
      rx  = 1'b1;
      rst = 1'b1;
      tick(10);
      check_val("reset_busy_idle", {31'd0, rxBusy}, 32'd0);
      check_val("reset_no_pulses", valid_cnt + ferr_cnt, 32'd0);
   endtask

   task automatic test_word;
      int v0 = valid_cnt;
      int f0 = ferr_cnt;
      send_word(16'hA53C);
      wait_drain("word");
      check_val("word_valid_count", valid_cnt, v0 + 1);
      check_val("word_data", {16'd0, rxData}, {16'd0, 16'hA53C});
      check_val("word_no_ferr", ferr_cnt, f0);
   endtask

   task automatic test_glitch;
      int v0 = valid_cnt;
      int f0 = ferr_cnt;
      logic seen = 1'b0;
      rx = 1'b0;
      tick(2);
      rx = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         if (rxBusy === 1'b1) seen = 1'b1;
      end
      check_val("glitch_busy_seen", {31'd0, seen}, 32'd1);
      check_val("glitch_busy_after", {31'd0, rxBusy}, 32'd0);
      check_val("glitch_no_pulses", (valid_cnt - v0) + (ferr_cnt - f0), 32'd0);
   endtask

   task automatic test_frame_err;
      int v0 = valid_cnt;
      int f0 = ferr_cnt;
      send_byte(8'h55, 1'b0);
      rx = 1'b0;
      tick(40);
      rx = 1'b1;
      tick(2 * C);
      check_val("ferr_count", ferr_cnt, f0 + 1);
      check_val("ferr_no_valid", valid_cnt, v0);
      check_val("ferr_busy", {31'd0, rxBusy}, 32'd0);
      send_word(16'h1234);
      wait_drain("ferr_recover");
      check_val("ferr_recover_data", {16'd0, rxData}, {16'd0, 16'h1234});
      check_val("ferr_recover_count", valid_cnt, v0 + 1);
   endtask

   task automatic test_timeout;
      send_byte(8'hFF, 1'b1);
      tick(40);
      check_val("timeout_busy_dropped", {31'd0, rxBusy}, 32'd0);
      check_val("timeout_data_kept", {16'd0, rxData}, {16'd0, 16'h1234});
      exp_q.push_back(16'h0201);
      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b1);
      wait_drain("timeout_long");
      check_val("timeout_long_data", {16'd0, rxData}, {16'd0, 16'h0201});
      send_byte(8'hFF, 1'b1);
      tick(20);
      check_val("timeout_short_busy", {31'd0, rxBusy}, 32'd1);
      exp_q.push_back(16'h01FF);
      send_byte(8'h01, 1'b1);
      wait_drain("timeout_short");
      check_val("timeout_short_data", {16'd0, rxData}, {16'd0, 16'h01FF});
   endtask

   task automatic test_reset_mid;
      int v0;
      logic [7:0] hi = 8'hBE;
      send_byte(8'hEF, 1'b1);
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(hi[i]);
      rx = hi[4];
      tick(C / 2);
      rst = 1'b0;
      tick(3);
      check_val("midrst_busy", {31'd0, rxBusy}, 32'd0);
      check_val("midrst_data", {16'd0, rxData}, 32'd0);
      rx  = 1'b1;
      rst = 1'b1;
      tick(3 * C);
      v0 = valid_cnt;
      send_word(16'hBEEF);
      wait_drain("midrst");
      check_val("midrst_valid_count", valid_cnt, v0 + 1);
      check_val("midrst_word", {16'd0, rxData}, {16'd0, 16'hBEEF});
   endtask

   task automatic test_back_to_back;
      int v0 = valid_cnt;
      send_word(16'hC0DE);
      send_word(16'h7E81);
      wait_drain("b2b");
      check_val("b2b_valid_count", valid_cnt, v0 + 2);
      check_val("b2b_last_data", {16'd0, rxData}, {16'd0, 16'h7E81});
   endtask

   initial begin
      test_reset;
      test_word;
      test_glitch;
      test_frame_err;
      test_timeout;
      test_reset_mid;
      test_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1);
   end

endmodule
